// File: rtl/seg7_pkg.sv
// Shared types and constants for the 7-segment scan controller.
package seg7_pkg;

    // Width of one digit value fed to the shared seg7 decoder.
    localparam int SEG_W = 4;

    // Scan slot phase: all digits off, or the current digit lit.
    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } scan_state_t;

endpackage

// File: rtl/seg7_scan_timer.sv
// Slot timer for the digit scan: counts cycles within a slot, sequences
// BLANK -> SHOW, advances the current digit index round-robin and raises a
// one-cycle frame pulse after the last digit's slot has ended.
module seg7_scan_timer
    import seg7_pkg::*;
#(
    parameter  int N_DIGITS  = 4,
    parameter  int SCAN_DIV  = 50000,
    parameter  int BLANK_CYC = 16,
    localparam int IW        = $clog2(N_DIGITS)
) (
    input  logic          clk,
    input  logic          rst_n,
    output scan_state_t   state,
    output logic [IW-1:0] cur_idx,
    output logic          frame_tick
);

    localparam int            CW            = $clog2(SCAN_DIV);
    localparam logic [CW-1:0] CNT_LAST      = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_BLANK_END = CW'(BLANK_CYC - 1);
    localparam logic [IW-1:0] IDX_LAST      = IW'(N_DIGITS - 1);

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    scan_state_t   state_nxt;
    logic [IW-1:0] idx_nxt;
    logic          tick_nxt;
    logic          slot_end;

    assign slot_end = (cnt == CNT_LAST);

    // State register: slot counter, phase, digit index and frame pulse.
    always_ff @(posedge clk) begin
        // NOTE: registers use non-blocking assignments so every flop samples
        // the pre-edge values regardless of statement order.
        if (!rst_n) begin
            state      <= ST_BLANK;
            cnt        <= '0;
            cur_idx    <= '0;
            frame_tick <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            cur_idx    <= idx_nxt;
            frame_tick <= tick_nxt;
        end
    end

    // Next-state: counter wraps at the slot end, where the index advances and
    // the phase returns to BLANK; SHOW starts after the blank window.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        cnt_nxt   = slot_end ? '0 : cnt + 1'b1;
        state_nxt = state;
        idx_nxt   = cur_idx;
        if (slot_end) begin
            state_nxt = ST_BLANK;
            idx_nxt   = (cur_idx == IDX_LAST) ? '0 : cur_idx + 1'b1;
        end else if (cnt == CNT_BLANK_END) begin
            state_nxt = ST_SHOW;
        end
    end

    // Output: frame pulse is raised for the cycle after the last digit's slot.
    always_comb begin
        tick_nxt = slot_end && (cur_idx == IDX_LAST);
    end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan controller for N_DIGITS 7-segment digits sharing one
// decoder. Holds one value per digit, drives the decoder input and blanking,
// and an active-low one-hot digit select. Writes to the digit currently lit
// are held off until its slot ends, so a value only changes while blanked.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter  int N_DIGITS  = 4,
    parameter  int SCAN_DIV  = 50000,
    parameter  int BLANK_CYC = 16,
    localparam int IW        = $clog2(N_DIGITS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_en,
    input  logic [IW-1:0]       wr_idx,
    input  logic [SEG_W-1:0]    wr_data,
    output logic                wr_ready,
    input  logic [N_DIGITS-1:0] blank_mask,
    output logic [SEG_W-1:0]    dec_in,
    output logic                dec_clear,
    output logic [N_DIGITS-1:0] digit_sel_n,
    output logic                frame_tick
);

    scan_state_t         state;
    logic [IW-1:0]       cur_idx;
    logic [SEG_W-1:0]    val [N_DIGITS];
    logic [N_DIGITS-1:0] cur_onehot;
    logic                wr_accept;

    seg7_scan_timer #(
        .N_DIGITS  (N_DIGITS),
        .SCAN_DIV  (SCAN_DIV),
        .BLANK_CYC (BLANK_CYC)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .state      (state),
        .cur_idx    (cur_idx),
        .frame_tick (frame_tick)
    );

    // Only the digit being lit is write-protected; out-of-range indices never
    // match cur_idx, so they are always ready and simply dropped below.
    assign wr_ready  = !((state == ST_SHOW) && (wr_idx == cur_idx));
    assign wr_accept = wr_en && wr_ready;

    // Value register file: one entry per digit, written on accepted requests.
    always_ff @(posedge clk) begin
        // NOTE: the value storage is reset on purpose: the display must show
        // zeros after reset, including a reset taken in the middle of a scan.
        if (!rst_n) begin
            for (int i = 0; i < N_DIGITS; i++) begin
                val[i] <= '0;
            end
        end else if (wr_accept) begin
            for (int i = 0; i < N_DIGITS; i++) begin
                if (wr_idx == IW'(i)) begin
                    val[i] <= wr_data;
                end
            end
        end
    end

    // Output decode from registered state: select, decoder value and blanking.
    always_comb begin
        cur_onehot = '0;
        dec_in     = '0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (cur_idx == IW'(i)) begin
                cur_onehot[i] = 1'b1;
                dec_in        = val[i];
            end
        end
        digit_sel_n = (state == ST_SHOW) ? ~cur_onehot : '1;
        dec_clear   = (state == ST_BLANK) || (|(blank_mask & cur_onehot));
    end

endmodule
